s6_icap_reboot_master: RTL
==========================

Name: s6_icap_reboot_master

Overview:
- Wishbone master that drives the Spartan-6 ICAP Wishbone slave to trigger a multiboot reconfiguration (IPROG) to a host-selected flash address.
- On a go pulse it issues a fixed 14-word write sequence, one Wishbone write per word, honouring the slave's slow, multi-cycle ack.
- Sits in the main clock domain between the settings-register bank and the ICAP slave port.
- Reports busy, done and timeout status.

Parameters:
- SPI_OPCODE, 8'h0B, SPI read opcode placed in GENERAL2 and GENERAL4 high bytes.
- GAP_CYCLES, 16, minimum idle clk cycles between the end of one write and the next stb_o assertion; range 1..255.
- TIMEOUT_CYCLES, 1023, clk cycles to wait for ack_i before aborting; range 1..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- go  input  1  single-cycle start pulse; ignored unless idle
- boot_addr  input  24  flash byte address of the target image
- fallback_addr  input  24  flash byte address of the fallback (golden) image
- cyc_o  output  1  Wishbone cycle
- stb_o  output  1  Wishbone strobe
- we_o  output  1  Wishbone write enable; 1 whenever stb_o=1
- dat_o  output  32  write data; [31:16]=0, [15:0]=ICAP word
- ack_i  input  1  Wishbone ack from the ICAP slave; may stay high for several clk cycles
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after the last word is acked
- timeout  output  1  sticky error flag; cleared by reset or the next accepted go
- word_idx  output  4  index of the current or last word (debug)

Behaviour:
- Reset values: cyc_o=0, stb_o=0, we_o=0, dat_o=0, busy=0, done=0, timeout=0, word_idx=0, FSM in IDLE.
- Reset is honoured in every state, including mid-transaction. stb_o and cyc_o drop the cycle after reset is sampled, and no further words are issued.
- boot_addr and fallback_addr are captured into internal registers on the accepted go. Later input changes do not affect the running sequence.
- Word table, index 0..13:
  - 0: FFFF
  - 1: AA99
  - 2: 5566
  - 3: 3261
  - 4: boot[15:0]
  - 5: 3281
  - 6: {SPI_OPCODE, boot[23:16]}
  - 7: 32A1
  - 8: fallback[15:0]
  - 9: 32C1
  - 10: {SPI_OPCODE, fallback[23:16]}
  - 11: 30A1
  - 12: 000E
  - 13: 2000
- IDLE: busy=0.
  - go=1: latch addresses, word_idx<=0, timeout<=0, busy<=1, go to REQ.
  - go=1 while busy=1 is ignored.
- REQ: one cycle.
  - Drive cyc_o=1, stb_o=1, we_o=1, dat_o={16'h0, word[word_idx]}.
  - Load the timeout counter with TIMEOUT_CYCLES.
  - Go to WAIT_ACK.
- WAIT_ACK: hold cyc_o, stb_o, we_o and dat_o stable.
  - On the first cycle ack_i=1: stb_o<=0, cyc_o<=0, go to ACK_LOW.
  - Otherwise decrement the counter. When it reaches 0: stb_o<=0, cyc_o<=0, timeout<=1, busy<=0, go to IDLE. No further words are issued.
- ACK_LOW: wait until ack_i=0. This absorbs the slave's multi-cycle ack so a single ack is never counted twice.
  - Then load the gap counter with GAP_CYCLES and go to GAP.
- GAP: count down to 0.
  - If word_idx=13: done pulse, busy<=0, go to IDLE.
  - Else word_idx<=word_idx+1, go to REQ.
- Simultaneous events:
  - go in the same cycle as done is ignored; a new go is accepted from the following cycle.
  - ack_i already high when entering REQ counts as the ack only once WAIT_ACK samples it.
- Total time (slave ack latency L clk cycles per word, ack high for H cycles): 14 × (1 + L + H + GAP_CYCLES) clk cycles, approximately.

Test Plan:
- Normal sequence: reset; boot_addr=24'h340000, fallback_addr=0; go; slave model acks after 8 clk for 4 clk -> exactly 14 writes with data FFFF, AA99, 5566, 3261, 0000, 3281, 0B34, 32A1, 0000, 32C1, 0B00, 30A1, 000E, 2000; one done pulse; busy low afterwards; timeout=0.
- Gap and edge rule: ack held high 10 clk -> stb_o never reasserts while ack_i=1; at least 16 idle cycles between stb_o fall and the next rise; no duplicate word.
- Timeout: slave never acks word 3 (TIMEOUT_CYCLES=1023) -> stb_o drops 1023 cycles after REQ; timeout=1; word_idx=3; no done; a subsequent go clears timeout and restarts at word 0.
- Re-trigger: go pulsed again while busy, and boot_addr changed mid-run -> ignored; words 4 and 6 still carry the originally latched address.
- Reset mid-operation: assert reset during WAIT_ACK of word 7 -> next cycle all outputs at reset values; no further stb_o until a new go.
- Back-to-back runs: go on the cycle after done -> second full 14-word sequence, identical to the first.

Source files
------------

// File: rtl/s6_icap_reboot_master.sv
//------------------------------------------------------------------------------
// Module   : s6_icap_reboot_master
// Purpose  : Wishbone master that writes the fixed 14-word Spartan-6 IPROG
//            sequence into the ICAP Wishbone slave, triggering a multiboot
//            reconfiguration to a host-selected flash address.
// Ports    :
//   clk, reset        - system clock, synchronous active-high reset
//   go                - single-cycle start pulse (ignored unless idle)
//   boot_addr         - flash byte address of the target image
//   fallback_addr     - flash byte address of the golden image
//   cyc_o/stb_o/we_o  - Wishbone control (all three move together)
//   dat_o             - write data, ICAP word in [15:0], upper half zero
//   ack_i             - Wishbone ack, may stay high for several cycles
//   busy/done/timeout - status: in progress / end pulse / sticky abort flag
//   word_idx          - index of the current or last word
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module s6_icap_reboot_master #(
  parameter logic [7:0]  SPI_OPCODE     = 8'h0B,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] boot_addr,
  input  logic [23:0] fallback_addr,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [3:0]  word_idx
);

  localparam logic [2:0]  c_S_IDLE     = 3'd0;
  localparam logic [2:0]  c_S_REQ      = 3'd1;
  localparam logic [2:0]  c_S_WAIT_ACK = 3'd2;
  localparam logic [2:0]  c_S_ACK_LOW  = 3'd3;
  localparam logic [2:0]  c_S_GAP      = 3'd4;

  localparam logic [3:0]  c_LAST_WORD  = 4'd13;
  localparam logic [15:0] c_TO_LOAD    = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  c_GAP_LOAD   = 8'(GAP_CYCLES);

  logic [2:0]  r_state;
  logic [23:0] r_boot;
  logic [23:0] r_fallback;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_gap_cnt;
  logic [3:0]  r_word_idx;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_dat;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;

  logic [15:0] w_word;

  // IPROG word table; address-dependent entries come from the copies latched
  // at go so the host may change its inputs while the sequence runs.
  always_comb begin
    w_word = 16'h2000;
    case (r_word_idx)
      4'd0:    w_word = 16'hFFFF;
      4'd1:    w_word = 16'hAA99;
      4'd2:    w_word = 16'h5566;
      4'd3:    w_word = 16'h3261;
      4'd4:    w_word = r_boot[15:0];
      4'd5:    w_word = 16'h3281;
      4'd6:    w_word = {SPI_OPCODE, r_boot[23:16]};
      4'd7:    w_word = 16'h32A1;
      4'd8:    w_word = r_fallback[15:0];
      4'd9:    w_word = 16'h32C1;
      4'd10:   w_word = {SPI_OPCODE, r_fallback[23:16]};
      4'd11:   w_word = 16'h30A1;
      4'd12:   w_word = 16'h000E;
      default: w_word = 16'h2000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_boot     <= 24'h0;
      r_fallback <= 24'h0;
      r_to_cnt   <= 16'h0;
      r_gap_cnt  <= 8'h0;
      r_word_idx <= 4'h0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_dat      <= 32'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          // r_done is high only in the cycle right after completion; a go
          // coinciding with it is deliberately dropped.
          if (go && !r_done) begin
            r_boot     <= boot_addr;
            r_fallback <= fallback_addr;
            r_word_idx <= 4'h0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= c_S_REQ;
          end
        end

        c_S_REQ: begin
          r_cyc    <= 1'b1;
          r_stb    <= 1'b1;
          r_we     <= 1'b1;
          r_dat    <= {16'h0, w_word};
          r_to_cnt <= c_TO_LOAD;
          r_state  <= c_S_WAIT_ACK;
        end

        c_S_WAIT_ACK: begin
          if (ack_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= c_S_ACK_LOW;
          end else if (r_to_cnt <= 16'd1) begin
            // Counter would reach zero this cycle: abandon the sequence.
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= c_S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt - 16'd1;
          end
        end

        c_S_ACK_LOW: begin
          // The slave may hold ack for several cycles; wait for its release
          // so the next request cannot be acked by the previous ack.
          if (!ack_i) begin
            r_gap_cnt <= c_GAP_LOAD;
            r_state   <= c_S_GAP;
          end
        end

        c_S_GAP: begin
          if (r_gap_cnt > 8'd1) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end else if (r_word_idx == c_LAST_WORD) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_S_IDLE;
          end else begin
            r_word_idx <= r_word_idx + 4'd1;
            r_state    <= c_S_REQ;
          end
        end

        default: begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign cyc_o    = r_cyc;
  assign stb_o    = r_stb;
  assign we_o     = r_we;
  assign dat_o    = r_dat;
  assign busy     = r_busy;
  assign done     = r_done;
  assign timeout  = r_timeout;
  assign word_idx = r_word_idx;

endmodule

`default_nettype wire
